// File: rtl/elink_trig_pkg.sv
// Shared constants and types for the e-link trigger-sum datapath.
//   TRIG_DATA_W  : width of one e-link trigger-primitive word
//   TRIG_SUM_W   : width of the saturated four-link trigger sum
//   TRIG_SUM_MAX : saturation ceiling of the trigger sum
package elink_trig_pkg;

  localparam int TRIG_DATA_W  = 12;
  localparam int TRIG_SUM_W   = 13;
  localparam int TRIG_SUM_MAX = 8191;

  typedef logic [TRIG_DATA_W-1:0] trig_word_t;
  typedef logic [TRIG_SUM_W-1:0]  trig_sum_t;

endpackage

// File: rtl/elink_trig_pair_adder.sv
// Registered adder of two unsigned trigger words. The result is one bit
// wider than the inputs, so it cannot overflow.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears the sum to 0
//   a_i    : first operand  [DATA_W-1:0]
//   b_i    : second operand [DATA_W-1:0]
//   sum_o  : registered a_i + b_i [DATA_W:0]
module elink_trig_pair_adder
  import elink_trig_pkg::*;
#(
  parameter int DATA_W = TRIG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W:0]   sum_o
);

  logic [DATA_W:0] sum_d, sum_q;

  assign sum_d = {1'b0, a_i} + {1'b0, b_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/elink_trig_summer.sv
// Two-stage pipelined saturating sum of four e-link trigger words.
//   Stage 1: two pair adders register p0 = in1+in2 and p1 = in3+in4.
//   Stage 2: full sum p0+p1, clamped to 2^OUT_W-1, registered to data_out.
// Latency is 2 cycles, throughput one sum per cycle, no handshake.
// Ports:
//   clk               : rising-edge clock
//   rst_n             : asynchronous active-low reset, flushes the pipeline
//   data_in1..4       : unsigned trigger words [DATA_W-1:0]
//   data_out          : saturated registered sum [OUT_W-1:0]
//   sat_flag          : (only with ELINK_TRIG_SUMMER_SAT_FLAG_EN) 1 when the
//                       sample now on data_out was clamped
// Optional feature macro: ELINK_TRIG_SUMMER_SAT_FLAG_EN
module elink_trig_summer
  import elink_trig_pkg::*;
#(
  parameter int DATA_W = TRIG_DATA_W,
  parameter int OUT_W  = TRIG_SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
`ifdef ELINK_TRIG_SUMMER_SAT_FLAG_EN
  output logic              sat_flag,
`endif
  output logic [OUT_W-1:0]  data_out
);

  localparam int NUM_PAIRS = 2;
  localparam int SUM_W     = DATA_W + 2;
  // Ceiling evaluated in 32 bits so it stays valid for any OUT_W below 32.
  localparam logic [31:0] SAT_MAX = (32'd1 << OUT_W) - 32'd1;

  logic [2*NUM_PAIRS-1:0][DATA_W-1:0] din;
  logic [NUM_PAIRS-1:0][DATA_W:0]     p_q;

  assign din = {data_in4, data_in3, data_in2, data_in1};

  // Stage 1: pair k adds links 2k+1 and 2k+2.
  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
    elink_trig_pair_adder #(.DATA_W(DATA_W)) u_pair (
      .clk   (clk),
      .rst_n (rst_n),
      .a_i   (din[2*g]),
      .b_i   (din[2*g+1]),
      .sum_o (p_q[g])
    );
  end

  // Stage 2: full-width add then clamp; nothing is dropped before the compare.
  logic [SUM_W-1:0] s;
  logic             sat_d;
  logic [OUT_W-1:0] data_d, data_q;

  assign s      = {1'b0, p_q[0]} + {1'b0, p_q[1]};
  assign sat_d  = (32'(s) > SAT_MAX);
  assign data_d = sat_d ? OUT_W'(SAT_MAX) : OUT_W'(s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_out = data_q;

`ifdef ELINK_TRIG_SUMMER_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_elink_trig_summer.sv
// Directed self-checking bench for elink_trig_summer: reset, streaming
// vectors with hand-computed sums, saturation edges, mid-stream async reset.
module tb_elink_trig_summer;
  localparam int DATA_W = 12;
  localparam int OUT_W  = 13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] d1, d2, d3, d4;
  logic [OUT_W-1:0]  dout;
`ifdef ELINK_TRIG_SUMMER_SAT_FLAG_EN
  logic              sat;
`endif

  always #5 clk = ~clk;

  elink_trig_summer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in1 (d1),
    .data_in2 (d2),
    .data_in3 (d3),
    .data_in4 (d4),
`ifdef ELINK_TRIG_SUMMER_SAT_FLAG_EN
    .sat_flag (sat),
`endif
    .data_out (dout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flag(input string tag, input int exp);
`ifdef ELINK_TRIG_SUMMER_SAT_FLAG_EN
    chk({tag, "_flag"}, 32'(sat), 32'(exp));
`else
    if (exp < 0) $display("bad flag expectation %s", tag);
`endif
  endtask

  typedef struct {
    int    a, b, c, d, s, f;
    string tag;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string tag, input int a, b, c, d, s, f);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.d = d; v.s = s; v.f = f; v.tag = tag;
    vq.push_back(v);
  endfunction

  task automatic drive(input int a, b, c, d);
    d1 = DATA_W'(a); d2 = DATA_W'(b); d3 = DATA_W'(c); d4 = DATA_W'(d);
  endtask

  initial begin
    // Reset held with live inputs: output must stay 0, even before any edge.
    drive(1000, 1000, 1000, 1000);
    #1 chk("rst_async", 32'(dout), 0);
    chk_flag("rst_async", 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", 32'(dout), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_c1", 32'(dout), 0);
    @(posedge clk); @(negedge clk);
    chk("rel_c2", 32'(dout), 4000);
    chk_flag("rel_c2", 0);

    // Continuous stream, no gaps between vectors.
    add("ramp0", 0, 0, 0, 0, 0, 0);
    add("ramp1", 100, 100, 100, 100, 400, 0);
    add("ramp2", 500, 500, 500, 500, 2000, 0);
    add("ramp3", 1000, 1000, 1000, 1000, 4000, 0);
    add("ramp4", 1000, 1000, 1000, 1000, 4000, 0);
    add("ramp5", 500, 500, 500, 500, 2000, 0);
    add("ramp6", 100, 100, 100, 100, 400, 0);
    add("ramp7", 0, 0, 0, 0, 0, 0);
    add("mix_8190", 4095, 4095, 0, 0, 8190, 0);
    add("mix_10", 1, 2, 3, 4, 10, 0);
    add("mix_carry", 4095, 1, 0, 0, 4096, 0);
    add("mix_8000", 3000, 3000, 1000, 1000, 8000, 0);
    add("mix_x", 4095, 0, 4095, 0, 8190, 0);
    add("sat_all", 4095, 4095, 4095, 4095, 8191, 1);
    add("sat_8192", 4095, 4095, 1, 1, 8191, 1);
    add("edge_8191", 4095, 4095, 1, 0, 8191, 0);
    add("edge_8191b", 4095, 4095, 0, 1, 8191, 0);
    add("sat_2048", 2048, 2048, 2048, 2048, 8191, 1);
    add("small", 7, 0, 0, 0, 7, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) add("tog0", 0, 0, 0, 0, 0, 0);
      else            add("tog1", 4095, 4095, 4095, 4095, 8191, 1);
    end

    // Sum of vector i-1 is visible after the edge that samples vector i.
    for (int i = 0; i <= vq.size(); i++) begin
      if (i < vq.size()) drive(vq[i].a, vq[i].b, vq[i].c, vq[i].d);
      else               drive(0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      if (i >= 1) begin
        chk($sformatf("%s[%0d]", vq[i-1].tag, i-1), 32'(dout), 32'(vq[i-1].s));
        chk_flag($sformatf("%s[%0d]", vq[i-1].tag, i-1), vq[i-1].f);
      end
    end

    // Mid-stream short reset pulse between edges.
    drive(1000, 1000, 1000, 1000);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    chk("pre_rst", 32'(dout), 4000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("mid_async", 32'(dout), 0);
    chk_flag("mid_async", 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("refill_c1", 32'(dout), 0);
    @(posedge clk); @(negedge clk);
    chk("refill_c2", 32'(dout), 4000);
    @(posedge clk); @(negedge clk);
    chk("refill_c3", 32'(dout), 4000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/elink_trig_summer.md
Name: elink_trig_summer

Overview:
Sums four 12-bit e-link trigger-primitive words into one 13-bit trigger sum every clock cycle. It sits after the e-link trigger-word deserializers and before trigger-sum compression and formatting. It is fully pipelined: it accepts one new input set per cycle and has fixed latency. There is no handshake.

Parameters:
DATA_W, 12, width of each input trigger word (unsigned).
OUT_W, 13, width of data_out (unsigned); the sum saturates at 2^OUT_W-1.

Ports:
clk  input  1  system clock; all logic works on the rising edge.
rst_n  input  1  asynchronous active-low reset.
data_in1  input  DATA_W  trigger word, link 1, unsigned.
data_in2  input  DATA_W  trigger word, link 2, unsigned.
data_in3  input  DATA_W  trigger word, link 3, unsigned.
data_in4  input  DATA_W  trigger word, link 4, unsigned.
data_out  output  OUT_W  saturated sum of the four inputs, registered.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, all pipeline registers and data_out are 0 immediately, independent of clk. The first sample is taken on the first rising edge after rst_n rises.
- Stage 1 (edge N):
  - Register p0 = data_in1 + data_in2 and p1 = data_in3 + data_in4.
  - Each is DATA_W+1 bits wide, so neither can overflow.
- Stage 2 (edge N+1):
  - Form the full sum s = p0 + p1, DATA_W+2 bits wide (max 16380).
  - If s > 2^OUT_W-1 (8191), register data_out = 8191; otherwise register data_out = s.
- Latency: inputs sampled on edge N appear on data_out after edge N+1 (2 cycles). Throughput is one sum per cycle.
- Inputs are unsigned. There is no sign extension, no wrap-around and no truncation of the LSBs.
- Reset asserted mid-stream: the pipeline is flushed to 0. Outputs after release reflect only inputs sampled after release. Cycle 1 after release shows 0.
- Inputs that change exactly at a rising edge are sampled with normal setup/hold semantics. The block adds no extra input registering.
- All-zero inputs produce 0; steady inputs produce a steady output.

Optional Feature:
Macro ELINK_TRIG_SUMMER_SAT_FLAG_EN.
- When defined:
  - Add output port sat_flag (1 bit), registered in stage 2 alongside data_out.
  - sat_flag is 1 exactly when saturation was applied for that sample (s > 8191), else 0.
  - sat_flag resets to 0.
- When undefined: the port does not exist, and saturation behaviour of data_out is unchanged.

Decomposition:
- Package elink_trig_pkg holds:
  - constants TRIG_DATA_W=12, TRIG_SUM_W=13, TRIG_SUM_MAX=8191;
  - typedefs trig_word_t (12-bit unsigned) and trig_sum_t (13-bit unsigned).
- One sub-module, elink_trig_pair_adder: registered adder of two DATA_W words to DATA_W+1 bits, with async active-low reset. It is instantiated twice for stage 1.
- The stage-2 add, saturation and optional flag live in the top.

Test Plan:
- Reset: hold rst_n=0 with inputs at 1000 -> data_out=0 throughout. Release -> 4000 appears 2 cycles after the first sampling edge.
- Streaming ramp: all four inputs per cycle 0,100,500,1000,1000,500,100,0 -> data_out, 2 cycles later, 0,400,2000,4000,4000,2000,400,0.
- Mixed values: (4095,4095,0,0) -> 8190, no saturation, sat_flag=0. (1,2,3,4) -> 10.
- Saturation: all inputs 4095 -> data_out=8191, sat_flag=1. (4095,4095,1,1) -> 8191, sat_flag=1. (4095,4095,1,0) -> 8191, sat_flag=0.
- Mid-stream reset: drive a 1000s stream and pulse rst_n low for 0.3 cycle between edges -> data_out drops to 0 asynchronously. Pipeline refills with 2-cycle latency.
- Back-to-back toggling: alternate all-0 and all-4095 each cycle -> data_out alternates 0 and 8191 with 2-cycle latency, with no bubble.
